cnff_seq_driver: RTL and testbench



---
 rtl/cnff_seq_driver.sv | 110 +++++++++++
 tb/tb_cnff_seq_driver.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cnff_seq_driver.sv
// Drives a bank of cnff cells toward a target word, one addressed (c,n) command per cycle.
// Optional readback compare against fb_q is built when CNFF_VERIFY_EN is defined.
module cnff_seq_driver #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             cmd_c,
    output logic             cmd_n,
    output logic [IDX_W-1:0] cmd_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow,
    input  logic [WIDTH-1:0] fb_q,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_reg;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (idx == IDX_W'(WIDTH - 1));
        case (state)
            IDLE: begin
                accept = tgt_valid && tgt_ready;
                if (accept) state_nxt = SCAN;
            end
            SCAN:    if (last) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_reg   <= '0;
            idx       <= '0;
            tgt_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_c     <= 1'b0;
            cmd_n     <= 1'b0;
            cmd_sel   <= '0;
            shadow    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    tgt_reg   <= tgt_data;
                    idx       <= '0;
                    tgt_ready <= 1'b0;
                    busy      <= 1'b1;
                end
                SCAN: begin
                    idx <= idx + IDX_W'(1);
                    // 0->1 is a toggle (c=1), 1->0 is a clear (c=0): c simply equals the target bit
                    if (shadow[idx] != tgt_reg[idx]) begin
                        cmd_n       <= 1'b1;
                        cmd_sel     <= idx;
                        cmd_c       <= tgt_reg[idx];
                        shadow[idx] <= tgt_reg[idx];
                    end else begin
                        cmd_n <= 1'b0;
                    end
                end
                FLUSH: begin
                    cmd_n <= 1'b0;
                    cmd_c <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    tgt_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CNFF_VERIFY_EN
    // Bank has settled by DONE; a mismatch here latches until reset or the next accept.
    always_ff @(posedge clk) begin
        if (rst)                                 err <= 1'b0;
        else if (accept)                         err <= 1'b0;
        else if (state == DONE && fb_q != shadow) err <= 1'b1;
    end
`else
    logic unused_fb;
    assign unused_fb = ^fb_q;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_cnff_seq_driver.sv
// Randomized bench for cnff_seq_driver: a cnff bank model plus a per-target
// expected command list derived from old-state vs target bit differences.
module tb_cnff_seq_driver;
    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tgt_valid = 1'b0;
    logic [WIDTH-1:0] tgt_data = '0;
    logic             tgt_ready, cmd_c, cmd_n, busy, done, err;
    logic [IDX_W-1:0] cmd_sel;
    logic [WIDTH-1:0] shadow, fb_q;
    logic [WIDTH-1:0] bank;
    logic [WIDTH-1:0] model_state = '0;
    logic             fb_zero = 1'b0;
    int               n_chk = 0;
    int               n_fail = 0;

    cnff_seq_driver #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_data(tgt_data), .cmd_c(cmd_c), .cmd_n(cmd_n), .cmd_sel(cmd_sel),
        .busy(busy), .done(done), .shadow(shadow), .fb_q(fb_q), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural cnff bank: hold on n=0, clear on n=1,c=0, toggle on n=1,c=1.
    always @(posedge clk) begin
        if (rst)        bank <= '0;
        else if (cmd_n) bank[cmd_sel] <= cmd_c ? ~bank[cmd_sel] : 1'b0;
    end
    assign fb_q = fb_zero ? '0 : bank;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_flags"}, 32'({tgt_ready, busy, done, cmd_n}), 32'b1000);
        chk({tag, "_shadow"}, 32'(shadow), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    // Apply one target; abort_at>0 asserts rst on SCAN edge abort_at.
    task automatic run_target(input logic [WIDTH-1:0] tgt, input bit hold_junk, input int abort_at);
        bit ok;
        bit diff;
        logic exp_err;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            if (tgt_ready) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("ready_wait", 32'(ok), 32'h1);
        if (!ok) return;
        tgt_valid = 1'b1;
        tgt_data  = tgt;
        @(posedge clk); #1;
        tgt_valid = hold_junk;
        tgt_data  = WIDTH'($urandom);
        chk("accept_flags", 32'({tgt_ready, busy, done}), 32'b010);
        chk("err_clear", 32'(err), 32'h0);
        for (int k = 1; k <= WIDTH; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                tgt_valid = 1'b0;
                chk_reset_state("abort");
                model_state = '0;
                return;
            end
            @(posedge clk); #1;
            if (k == WIDTH) tgt_valid = 1'b0;
            diff = model_state[k-1] != tgt[k-1];
            chk("cmd_n", 32'(cmd_n), 32'(diff));
            if (diff) begin
                chk("cmd_sel", 32'(cmd_sel), 32'(k - 1));
                chk("cmd_c", 32'(cmd_c), 32'(tgt[k-1]));
            end
            chk("scan_flags", 32'({tgt_ready, busy, done}), 32'b010);
        end
        @(posedge clk); #1;
        chk("done_flags", 32'({tgt_ready, busy, done, cmd_n}), 32'b0110);
        chk("bank_at_done", 32'(bank), 32'(tgt));
        @(posedge clk); #1;
        chk("idle_flags", 32'({tgt_ready, busy, done}), 32'b100);
        chk("shadow", 32'(shadow), 32'(tgt));
        chk("bank", 32'(bank), 32'(tgt));
`ifdef CNFF_VERIFY_EN
        exp_err = fb_zero && (tgt != '0);
`else
        exp_err = 1'b0;
`endif
        chk("err", 32'(err), 32'(exp_err));
        model_state = tgt;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("reset");
        chk("reset_cmd", 32'({cmd_c, cmd_sel}), 32'h0);

        run_target(8'hA5, 1'b0, 0);
        run_target(8'h0F, 1'b0, 0);
        run_target(8'h0F, 1'b0, 0);
        run_target(8'h3C, 1'b1, 0);
        run_target(8'hC3, 1'b1, 5);
        run_target(8'h00, 1'b0, 0);
        run_target(8'hFF, 1'b0, 0);

`ifdef CNFF_VERIFY_EN
        fb_zero = 1'b1;
        run_target(8'h81, 1'b0, 0);
        fb_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'h1);
        run_target(8'h5A, 1'b0, 0);
`endif

        for (int t = 0; t < 20; t++) begin
            logic [WIDTH-1:0] r;
            int ab;
            r  = WIDTH'($urandom);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, WIDTH)) : 0;
            run_target(r, 1'($urandom_range(0, 1)), ab);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
